// File: rtl/collision_engine.sv
// Air-hockey collision engine: latches positions on a frame tick, checks paddles one per cycle,
// then resolves goal/paddle/wall. Optional feature macro: COLLISION_SPEEDUP_EN (adds speed output).
module collision_engine #(
  parameter int COORD_W     = 11,
  parameter int FIELD_W     = 100,
  parameter int FIELD_H     = 100,
  parameter int BALL_SIZE   = 4,
  parameter int PADDLE_W    = 4,
  parameter int PADDLE_H    = 40,
  parameter int NUM_PADDLES = 2,
  parameter int GOAL_Y0     = 30,
  parameter int GOAL_H      = 40,
  parameter int SCORE_W     = 4
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           serve,
  input  logic [COORD_W-1:0]             x_ball,
  input  logic [COORD_W-1:0]             y_ball,
  input  logic [NUM_PADDLES*COORD_W-1:0] x_paddles,
  input  logic [NUM_PADDLES*COORD_W-1:0] y_paddles,
  output logic                           horizontal,
  output logic                           vertical,
  output logic                           busy,
  output logic                           done,
  output logic                           hit_paddle,
  output logic                           goal_left,
  output logic                           goal_right,
  output logic [SCORE_W-1:0]             score_left,
  output logic [SCORE_W-1:0]             score_right
`ifdef COLLISION_SPEEDUP_EN
  ,
  output logic [2:0]                     speed
`endif
);
  localparam int IW  = (NUM_PADDLES > 1) ? $clog2(NUM_PADDLES) : 1;
  localparam int CW1 = COORD_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_PADDLE, S_UPDATE, S_GOAL} state_t;

  state_t             state;
  logic [COORD_W-1:0] xb, yb;
  logic [COORD_W-1:0] px_a [NUM_PADDLES];
  logic [COORD_W-1:0] py_a [NUM_PADDLES];
  logic [IW-1:0]      idx;
  logic               hit, hit_dir, goal_side;

  // All geometry is compared one bit wider so paddle/ball extents never wrap.
  logic [CW1-1:0] xb_e, yb_e, px_e, py_e;
  logic           cand, cand_dir, wl, wr, wt, wbot, in_mouth, gl, gr, last;

  always_comb begin
    xb_e     = {1'b0, xb};
    yb_e     = {1'b0, yb};
    px_e     = {1'b0, px_a[idx]};
    py_e     = {1'b0, py_a[idx]};
    cand     = (px_e <= xb_e) && (xb_e <= px_e + CW1'(PADDLE_W)) &&
               (py_e <= yb_e) && (yb_e <= py_e + CW1'(PADDLE_H));
    cand_dir = (xb_e + CW1'(BALL_SIZE / 2)) >= (px_e + CW1'(PADDLE_W / 2));
    wl       = (xb == '0);
    wr       = (xb_e + CW1'(BALL_SIZE)) == CW1'(FIELD_W - 1);
    wt       = (yb == '0);
    wbot     = (yb_e + CW1'(BALL_SIZE)) == CW1'(FIELD_H - 1);
    in_mouth = (yb_e >= CW1'(GOAL_Y0)) && (yb_e < CW1'(GOAL_Y0 + GOAL_H));
    gl       = wl && in_mouth;
    gr       = wr && in_mouth && !gl;
    last     = (idx == IW'(NUM_PADDLES - 1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      xb          <= '0;
      yb          <= '0;
      for (int i = 0; i < NUM_PADDLES; i++) begin
        px_a[i] <= '0;
        py_a[i] <= '0;
      end
      idx         <= '0;
      hit         <= 1'b0;
      hit_dir     <= 1'b0;
      goal_side   <= 1'b0;
      horizontal  <= 1'b0;
      vertical    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      hit_paddle  <= 1'b0;
      goal_left   <= 1'b0;
      goal_right  <= 1'b0;
      score_left  <= '0;
      score_right <= '0;
`ifdef COLLISION_SPEEDUP_EN
      speed       <= '0;
`endif
    end else begin
      done       <= 1'b0;
      hit_paddle <= 1'b0;
      goal_left  <= 1'b0;
      goal_right <= 1'b0;
      case (state)
        S_IDLE: if (enable) begin
          state <= S_LATCH;
          busy  <= 1'b1;
        end
        S_LATCH: begin
          xb <= x_ball;
          yb <= y_ball;
          for (int i = 0; i < NUM_PADDLES; i++) begin
            px_a[i] <= x_paddles[i*COORD_W +: COORD_W];
            py_a[i] <= y_paddles[i*COORD_W +: COORD_W];
          end
          idx   <= '0;
          hit   <= 1'b0;
          state <= S_PADDLE;
        end
        S_PADDLE: begin
          // First hitting paddle wins; later ones are ignored.
          if (!hit && cand) begin
            hit     <= 1'b1;
            hit_dir <= cand_dir;
          end
          if (last) state <= S_UPDATE;
          else      idx   <= idx + 1'b1;
        end
        S_UPDATE: begin
          done <= 1'b1;
          if (gl || gr) begin
            goal_left  <= gl;
            goal_right <= gr;
            goal_side  <= gl;
            if (gl && score_right != '1) score_right <= score_right + 1'b1;
            if (gr && score_left  != '1) score_left  <= score_left  + 1'b1;
            state <= S_GOAL;
          end else begin
            busy       <= 1'b0;
            hit_paddle <= hit;
            state      <= S_IDLE;
            if (hit) begin
              horizontal <= hit_dir;
`ifdef COLLISION_SPEEDUP_EN
              if (speed != 3'd7) speed <= speed + 3'd1;
`endif
            end else if (wl) horizontal <= 1'b1;
            else if (wr)     horizontal <= 1'b0;
            if (wt)        vertical <= 1'b0;
            else if (wbot) vertical <= 1'b1;
          end
        end
        S_GOAL: if (serve) begin
          horizontal <= !goal_side;
          vertical   <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
`ifdef COLLISION_SPEEDUP_EN
          speed      <= '0;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_collision_engine.sv
// Directed bench for collision_engine: walls, goals, paddles, corners, enable/reset hazards.
module tb_collision_engine;
  localparam int CW = 11;
  localparam int NP = 2;
  localparam int SW = 4;

  logic clock = 1'b0, reset_n = 1'b0, enable = 1'b0, serve = 1'b0;
  logic [CW-1:0] x_ball = '0, y_ball = '0;
  logic [NP*CW-1:0] x_paddles = '0, y_paddles = '0;
  logic horizontal, vertical, busy, done, hit_paddle, goal_left, goal_right;
  logic [SW-1:0] score_left, score_right;
`ifdef COLLISION_SPEEDUP_EN
  logic [2:0] speed;
`endif

  int passed = 0, total = 0;

  always #5 clock = ~clock;

  collision_engine dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .serve(serve),
    .x_ball(x_ball), .y_ball(y_ball), .x_paddles(x_paddles), .y_paddles(y_paddles),
    .horizontal(horizontal), .vertical(vertical), .busy(busy), .done(done),
    .hit_paddle(hit_paddle), .goal_left(goal_left), .goal_right(goal_right),
    .score_left(score_left), .score_right(score_right)
`ifdef COLLISION_SPEEDUP_EN
    , .speed(speed)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_paddles(input int x0, input int y0, input int x1, input int y1);
    x_paddles = {CW'(x1), CW'(x0)};
    y_paddles = {CW'(y1), CW'(y0)};
  endtask

  // Pulse enable for one cycle and wait (bounded) for done; returns cycles after the enable edge.
  task automatic frame(input int x, input int y, output int lat);
    x_ball = CW'(x);
    y_ball = CW'(y);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_serve();
    serve = 1'b1;
    tick();
    serve = 1'b0;
  endtask

  initial begin
    int lat, cnt;
    set_paddles(50, 80, 60, 80);
    repeat (3) tick();
    chk("rst_h", horizontal, 0);
    chk("rst_v", vertical, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sl", score_left, 0);
    chk("rst_sr", score_right, 0);
    reset_n = 1'b1;
    tick();

    // Left wall outside the goal mouth
    frame(0, 10, lat);
    chk("lw_lat", lat, 4);
    chk("lw_h", horizontal, 1);
    chk("lw_v", vertical, 1);
    chk("lw_goal", goal_left, 0);
    chk("lw_hit", hit_paddle, 0);
    chk("lw_busy", busy, 0);
    tick();
    chk("lw_done_pulse", done, 0);

    // Left goal: hold until serve, ignore enable meanwhile
    frame(0, 50, lat);
    chk("gl_lat", lat, 4);
    chk("gl_pulse", goal_left, 1);
    chk("gl_sr", score_right, 1);
    chk("gl_sl", score_left, 0);
    chk("gl_busy", busy, 1);
    tick();
    chk("gl_pulse_end", goal_left, 0);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    cnt = 0;
    repeat (8) begin tick(); if (done) cnt++; end
    chk("gl_en_ignored", cnt, 0);
    chk("gl_busy_hold", busy, 1);
    chk("gl_h_frozen", horizontal, 1);
    do_serve();
    chk("gl_srv_h", horizontal, 0);
    chk("gl_srv_v", vertical, 1);
    chk("gl_srv_busy", busy, 0);

    // Paddle 0 hit, then the same frame again
    set_paddles(10, 20, 90, 80);
    frame(12, 30, lat);
    chk("p0_lat", lat, 4);
    chk("p0_hit", hit_paddle, 1);
    chk("p0_h", horizontal, 1);
    frame(12, 30, lat);
    chk("p0_rep_hit", hit_paddle, 1);
    chk("p0_rep_h", horizontal, 1);

    // Right wall, then paddle 1 only
    frame(95, 10, lat);
    chk("rw_h", horizontal, 0);
    chk("rw_hit", hit_paddle, 0);
    set_paddles(90, 80, 10, 20);
    frame(12, 30, lat);
    chk("p1_hit", hit_paddle, 1);
    chk("p1_h", horizontal, 1);

    // Corner and bottom wall
    set_paddles(50, 80, 60, 80);
    frame(95, 10, lat);
    frame(0, 0, lat);
    chk("cn_h", horizontal, 1);
    chk("cn_v", vertical, 0);
    frame(40, 95, lat);
    chk("bw_v", vertical, 1);
    chk("bw_h", horizontal, 1);

    // Right goal
    frame(95, 50, lat);
    chk("gr_pulse", goal_right, 1);
    chk("gr_gl", goal_left, 0);
    chk("gr_sl", score_left, 1);
    chk("gr_sr", score_right, 1);
    do_serve();
    chk("gr_srv_h", horizontal, 1);
    serve = 1'b1;
    tick();
    serve = 1'b0;
    chk("srv_idle_ignored_busy", busy, 0);

    // enable re-asserted during LATCH must not start a second evaluation
    x_ball = CW'(40);
    y_ball = CW'(40);
    enable = 1'b1;
    tick();
    tick();
    enable = 1'b0;
    cnt = 0;
    repeat (12) begin tick(); if (done) cnt++; end
    chk("latch_en_once", cnt, 1);

    // Reset during PADDLE aborts
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    chk("pad_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    cnt = 0;
    repeat (2) begin tick(); if (done) cnt++; end
    reset_n = 1'b1;
    repeat (8) begin tick(); if (done) cnt++; end
    chk("abort_nodone", cnt, 0);
    chk("abort_h", horizontal, 0);
    chk("abort_v", vertical, 1);
    chk("abort_sl", score_left, 0);
    chk("abort_sr", score_right, 0);

    // Saturation: 16 left goals leave score_right at 15
    repeat (16) begin
      frame(0, 50, lat);
      do_serve();
    end
    chk("sat_sr", score_right, 15);
    chk("sat_sl", score_left, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
